// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
// Holds the arbiter FSM state encoding and the id-width helper.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      GAP       = 2'd2
   } arb_state_t;

   // Width of an index into n items, never narrower than one bit.
   function automatic int ID_W(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Winner select: requester 0 optionally absolute priority, others round-robin from ptr.
// Latency: winner is combinational; ptr updates on the grant edge. No backpressure of its own.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter bit PRIO0 = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic                      grant,
   output logic [ID_W(N_REQ)-1:0]    winner
);

   localparam int W = ID_W(N_REQ);

   logic [W-1:0] ptr;
   logic [W-1:0] rr_win;
   logic         found;
   logic         prio_hit;
   int           idx;

   always_comb begin
      rr_win = ptr;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!found && req[W'(idx)]) begin
            rr_win = W'(idx);
            found  = 1'b1;
         end
      end
   end

   assign prio_hit = PRIO0 && req[0];
   assign winner   = prio_hit ? '0 : rr_win;

   // A priority grant to requester 0 leaves the round-robin position untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant && !prio_hit) begin
         ptr <= (int'(rr_win) + 1 == N_REQ) ? '0 : rr_win + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters; reports done/timeout to the owner.
// Latency: valid sampled at edge n -> strobe/accept in cycle n+1; holds off while u_tx_busy.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int DATA_LEN = 8,
   parameter bit PRIO0    = 1'b1,
   parameter int MAX_WAIT = 50000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ*DATA_LEN-1:0]    req_data,
   output logic [N_REQ-1:0]             req_accept,
   output logic [N_REQ-1:0]             req_done,
   output logic [N_REQ-1:0]             req_error,
   input  logic                         u_tx_busy,
   input  logic                         u_tx_done,
   output logic                         u_send_sig,
   output logic [DATA_LEN-1:0]          u_data_out,
   output logic                         busy,
   output logic [ID_W(N_REQ)-1:0]       grant_id
);

   localparam int IW = ID_W(N_REQ);
   localparam int CW = ID_W(MAX_WAIT);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   arb_state_t      state;
   arb_state_t      state_nxt;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   winner;
   logic            grant;
   logic            done_ev;
   logic            err_ev;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PRIO0 (PRIO0)
   ) u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    (req_valid),
      .grant  (grant),
      .winner (winner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Done is checked before expiry so a completion on the last cycle is never reported as an error.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done_ev   = 1'b0;
      err_ev    = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid && !u_tx_busy) begin
               grant     = 1'b1;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (u_tx_done) begin
               done_ev   = 1'b1;
               state_nxt = GAP;
            end else if (cnt == CW'(MAX_WAIT - 1)) begin
               err_ev    = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         u_send_sig <= 1'b0;
         req_accept <= '0;
         req_done   <= '0;
         req_error  <= '0;
         u_data_out <= '0;
         grant_id   <= '0;
         cnt        <= '0;
      end else begin
         u_send_sig <= grant;
         req_accept <= grant   ? (ONE << winner)   : '0;
         req_done   <= done_ev ? (ONE << grant_id) : '0;
         req_error  <= err_ev  ? (ONE << grant_id) : '0;
         if (grant) begin
            u_data_out <= req_data[int'(winner)*DATA_LEN +: DATA_LEN];
            grant_id   <= winner;
            cnt        <= '0;
         end else if (state == WAIT_DONE) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a PRIO0=1 and a PRIO0=0 instance share stimulus, MAX_WAIT=20.
// Directed vector table, hand sequences for multi-cycle corners, then random traffic vs a reference model.
module tb_uart_tx_arbiter;

   localparam int N    = 3;
   localparam int MAXW = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_data = '0;
   logic        u_tx_busy = 1'b0;
   logic        u_tx_done = 1'b0;

   logic [2:0] p_acc, p_done, p_err, r_acc, r_done, r_err;
   logic       p_send, p_busy, r_send, r_busy;
   logic [7:0] p_data, r_data;
   logic [1:0] p_gid, r_gid;
   logic [20:0] p_vec, r_vec;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .DATA_LEN(8), .PRIO0(1'b1), .MAX_WAIT(MAXW)) dut_p (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_accept(p_acc), .req_done(p_done), .req_error(p_err),
      .u_tx_busy(u_tx_busy), .u_tx_done(u_tx_done), .u_send_sig(p_send),
      .u_data_out(p_data), .busy(p_busy), .grant_id(p_gid));

   uart_tx_arbiter #(.N_REQ(N), .DATA_LEN(8), .PRIO0(1'b0), .MAX_WAIT(MAXW)) dut_r (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_accept(r_acc), .req_done(r_done), .req_error(r_err),
      .u_tx_busy(u_tx_busy), .u_tx_done(u_tx_done), .u_send_sig(r_send),
      .u_data_out(r_data), .busy(r_busy), .grant_id(r_gid));

   assign p_vec = {p_send, p_acc, p_done, p_err, p_busy, p_gid, p_data};
   assign r_vec = {r_send, r_acc, r_done, r_err, r_busy, r_gid, r_data};

   typedef struct {
      logic [2:0]  v;
      logic [23:0] d;
      logic        ub;
      logic        dn;
      logic [20:0] exp;
   } row_t;

   typedef struct {
      int         ph;    // 0 idle, 1 awaiting completion, 2 gap
      int         own;
      int         el;    // cycles spent awaiting completion
      int         ptr;
      logic       send;
      logic [2:0] acc;
      logic [2:0] dn;
      logic [2:0] er;
      logic [7:0] dat;
   } mdl_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic row_t mk(input logic [2:0] v, input logic [23:0] d, input logic ub,
                               input logic dn, input logic send, input logic [2:0] acc,
                               input logic [2:0] don, input logic [2:0] er, input logic bsy,
                               input logic [1:0] gid, input logic [7:0] dat);
      row_t r;
      r.v = v; r.d = d; r.ub = ub; r.dn = dn;
      r.exp = {send, acc, don, er, bsy, gid, dat};
      return r;
   endfunction

   function automatic mdl_t mreset();
      mdl_t m;
      m.ph = 0; m.own = 0; m.el = 0; m.ptr = 0;
      m.send = 1'b0; m.acc = '0; m.dn = '0; m.er = '0; m.dat = '0;
      return m;
   endfunction

   function automatic logic [20:0] mexp(input mdl_t m);
      return {m.send, m.acc, m.dn, m.er, (m.ph != 0), 2'(m.own), m.dat};
   endfunction

   // Outcome of one clock edge given the inputs present at that edge.
   function automatic mdl_t mstep(input mdl_t m, input bit prio, input logic [2:0] v,
                                  input logic [23:0] d, input logic ub, input logic dn);
      mdl_t n = m;
      int w = -1;
      n.send = 1'b0; n.acc = '0; n.dn = '0; n.er = '0;
      if (m.ph == 0) begin
         if (v != 0 && !ub) begin
            if (prio && v[0]) begin
               w = 0;
            end else begin
               for (int i = 0; i < N; i++)
                  if (w < 0 && v[(m.ptr + i) % N]) w = (m.ptr + i) % N;
               n.ptr = (w + 1) % N;
            end
            n.own = w; n.el = 0; n.ph = 1;
            n.send = 1'b1; n.acc = 3'b001 << w; n.dat = d[w*8 +: 8];
         end
      end else if (m.ph == 1) begin
         n.el = m.el + 1;
         if (dn) begin
            n.dn = 3'b001 << m.own; n.ph = 2;
         end else if (n.el == MAXW) begin
            n.er = 3'b001 << m.own; n.ph = 2;
         end
      end else begin
         n.ph = 0;
      end
      return n;
   endfunction

   task automatic apply(input row_t r);
      req_valid = r.v; req_data = r.d; u_tx_busy = r.ub; u_tx_done = r.dn;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_valid = '0; u_tx_done = 1'b0; u_tx_busy = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clk); u_tx_done = 1'b1;
      @(negedge clk); u_tx_done = 1'b0;
   endtask

   task automatic wait_strobe(input bit use_r, output logic [7:0] d, output logic [1:0] g);
      d = '0; g = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (use_r ? r_send : p_send) begin
            d = use_r ? r_data : p_data;
            g = use_r ? r_gid : p_gid;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL strobe_timeout: got no strobe in 60 cycles expected one");
   endtask

   initial begin
      row_t       tbl[$];
      logic [7:0] d;
      logic [1:0] g;
      logic [7:0] exp_d[4];
      int         exp_g[4];
      int         ek, dk;
      logic [2:0] eb, db;
      mdl_t       mp, mr;

      // Reset state
      @(negedge clk); @(negedge clk);
      check("reset_p", p_vec, 0);
      check("reset_r", r_vec, 0);

      // Single request, completion, busy hold-off, stray done in IDLE (PRIO0=1 instance)
      tbl.push_back(mk(3'b001, 24'hCC, 1'b0, 1'b0, 1'b1, 3'b001, 3'b0, 3'b0, 1'b1, 2'd0, 8'hCC));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(3'b0, 24'hCC, 1'b0, 1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 1'b1, 2'd0, 8'hCC));
      tbl.push_back(mk(3'b0, 24'hCC, 1'b0, 1'b1, 1'b0, 3'b0, 3'b001, 3'b0, 1'b1, 2'd0, 8'hCC));
      tbl.push_back(mk(3'b0, 24'hCC, 1'b0, 1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 2'd0, 8'hCC));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(3'b010, 24'h5A00, 1'b1, 1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 2'd0, 8'hCC));
      tbl.push_back(mk(3'b010, 24'h5A00, 1'b0, 1'b0, 1'b1, 3'b010, 3'b0, 3'b0, 1'b1, 2'd1, 8'h5A));
      tbl.push_back(mk(3'b0, 24'h5A00, 1'b0, 1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 1'b1, 2'd1, 8'h5A));
      tbl.push_back(mk(3'b0, 24'h5A00, 1'b0, 1'b1, 1'b0, 3'b0, 3'b010, 3'b0, 1'b1, 2'd1, 8'h5A));
      tbl.push_back(mk(3'b0, 24'h0, 1'b0, 1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 2'd1, 8'h5A));
      tbl.push_back(mk(3'b0, 24'h0, 1'b0, 1'b1, 1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 2'd1, 8'h5A));
      tbl.push_back(mk(3'b0, 24'h0, 1'b0, 1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 2'd1, 8'h5A));

      reset = 1'b0;
      apply(tbl[0]);
      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         check($sformatf("vec%0d", k), p_vec, tbl[k].exp);
         if (k + 1 < tbl.size()) apply(tbl[k+1]);
      end

      // Round robin with immediate completion (PRIO0=0 instance)
      do_reset();
      req_valid = 3'b111; req_data = 24'h332211; u_tx_done = 1'b1;
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h11};
      exp_g = '{0, 1, 2, 0};
      for (int i = 0; i < 4; i++) begin
         wait_strobe(1'b1, d, g);
         check($sformatf("rr_data%0d", i), d, exp_d[i]);
         check($sformatf("rr_gid%0d", i), g, exp_g[i]);
      end
      u_tx_done = 1'b0; req_valid = '0;

      // Priority pre-empts the round robin (PRIO0=1 instance)
      do_reset();
      req_valid = 3'b110; req_data = 24'h332200;
      wait_strobe(1'b0, d, g);
      check("prio_first_gid", g, 1);
      req_valid = 3'b101; req_data = 24'h3300CC;
      pulse_done();
      wait_strobe(1'b0, d, g);
      check("prio_req0_gid", g, 0);
      check("prio_req0_data", d, 8'hCC);
      req_valid = 3'b100;
      pulse_done();
      wait_strobe(1'b0, d, g);
      check("prio_req2_gid", g, 2);
      check("prio_req2_data", d, 8'h33);
      req_valid = '0;
      pulse_done();

      // Timeout, then completion landing on the expiry cycle
      do_reset();
      req_valid = 3'b001; req_data = 24'h0000AB;
      wait_strobe(1'b0, d, g);
      req_valid = '0;
      ek = -1; dk = -1; eb = '0; db = '0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (p_err != 0 && ek < 0) begin ek = k; eb = p_err; end
         if (p_done != 0 && dk < 0) begin dk = k; db = p_done; end
      end
      check("timeout_cycle", ek, 20);
      check("timeout_bits", eb, 3'b001);
      check("timeout_no_done", dk, -1);
      req_valid = 3'b001; req_data = 24'h0000AC;
      wait_strobe(1'b0, d, g);
      req_valid = '0;
      ek = -1; dk = -1; eb = '0; db = '0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (p_err != 0 && ek < 0) begin ek = k; eb = p_err; end
         if (p_done != 0 && dk < 0) begin dk = k; db = p_done; end
         if (k == 19) u_tx_done = 1'b1;
         if (k == 20) u_tx_done = 1'b0;
      end
      check("expiry_done_cycle", dk, 20);
      check("expiry_done_bits", db, 3'b001);
      check("expiry_no_error", ek, -1);

      // Reset mid-transfer clears outputs and the round-robin pointer (PRIO0=0 instance)
      do_reset();
      req_valid = 3'b001; req_data = 24'h332211;
      wait_strobe(1'b1, d, g);
      check("rst_pre_gid0", g, 0);
      req_valid = '0;
      pulse_done();
      req_valid = 3'b010;
      wait_strobe(1'b1, d, g);
      check("rst_pre_gid1", g, 1);
      req_valid = 3'b110;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("rst_async_clear", r_vec, 0);
      @(negedge clk);
      check("rst_held_clear", r_vec, 0);
      reset = 1'b0;
      wait_strobe(1'b1, d, g);
      check("rst_regrant_gid", g, 1);
      check("rst_regrant_data", d, 8'h22);
      req_valid = '0;
      pulse_done();

      // Random traffic against the reference model, both instances
      do_reset();
      mp = mstep(mreset(), 1'b1, req_valid, req_data, u_tx_busy, u_tx_done);
      mr = mstep(mreset(), 1'b0, req_valid, req_data, u_tx_busy, u_tx_done);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         check("rand_prio", p_vec, mexp(mp));
         check("rand_rr", r_vec, mexp(mr));
         req_valid = 3'($urandom_range(0, 7));
         req_data  = 24'($urandom);
         u_tx_busy = ($urandom_range(0, 3) == 0);
         u_tx_done = ($urandom_range(0, 7) == 0);
         mp = mstep(mp, 1'b1, req_valid, req_data, u_tx_busy, u_tx_done);
         mr = mstep(mr, 1'b0, req_valid, req_data, u_tx_busy, u_tx_done);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
